bcd_to_bin_conv: RTL and testbench

//   Converts a packed multi-digit BCD word (e.g. a chain of BCD count digits) into
//   an unsigned binary value for arithmetic/compare logic and the 6502 data path.

---
 rtl/bcd_to_bin_conv_if.sv | 26 ++
 rtl/bcd_to_bin_conv.sv | 80 ++++++++
 tb/tb_bcd_to_bin_conv.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_conv_if.sv
// bcd_to_bin_conv_if: valid/ready handshake bundle for the BCD-to-binary converter.
//   Input side : in_valid, in_ready, bcd_in (packed BCD, MSD in the top nibble)
//   Output side: out_valid, out_ready, bin_out, err
//   master = producer/consumer around the converter, slave = the converter itself.
interface bcd_to_bin_conv_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, err
    );
endinterface

// File: rtl/bcd_to_bin_conv.sv
// bcd_to_bin_conv: iterative packed-BCD to unsigned binary converter, one digit per clock, MSD first.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : bcd_to_bin_conv_if.slave (in_valid/in_ready/bcd_in, out_valid/out_ready/bin_out/err)
//   Optional macro BCD2BIN_ZERO_SKIP_EN: start conversion at the highest non-zero digit.
module bcd_to_bin_conv #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input logic              clk,
    input logic              reset_n,
    bcd_to_bin_conv_if.slave bus
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state;
    logic [4*DIGITS-1:0] sh;
    logic [BIN_W-1:0]    acc;
    logic [BIN_W-1:0]    acc_next;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       start;
    logic [IW+1:0]       base;
    logic [3:0]          d;

    assign base         = {idx, 2'b00};
    assign d            = sh[base +: 4];
    // acc*10 + d as shift-add; wraps mod 2^BIN_W for out-of-range digits
    assign acc_next     = (acc << 3) + (acc << 1) + BIN_W'(d);
    assign bus.in_ready = state == IDLE;

`ifdef BCD2BIN_ZERO_SKIP_EN
    // Ascending scan so the highest non-zero digit wins; all-zero word starts at digit 0
    always_comb begin
        start = '0;
        for (int k = 0; k < DIGITS; k++)
            if (bus.bcd_in[4*k +: 4] != 4'd0) start = IW'(k);
    end
`else
    assign start = IW'(DIGITS - 1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sh            <= '0;
            acc           <= '0;
            idx           <= '0;
            bus.bin_out   <= '0;
            bus.err       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sh      <= bus.bcd_in;
                    acc     <= '0;
                    bus.err <= 1'b0;
                    idx     <= start;
                    state   <= CONV;
                end
                CONV: begin
                    acc     <= acc_next;
                    bus.err <= bus.err | (d > 4'd9);
                    idx     <= idx - 1'b1;
                    if (idx == '0) begin
                        bus.bin_out   <= acc_next;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_conv.sv
// tb_bcd_to_bin_conv: table-driven self-checking bench for bcd_to_bin_conv plus backpressure and reset-abort sequences.
module tb_bcd_to_bin_conv;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_to_bin_conv_if #(.DIGITS(4), .BIN_W(14)) bus ();

    bcd_to_bin_conv #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
        int          skip_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Present one word for a single cycle, then count edges until out_valid
    task automatic send(input logic [15:0] bcd, output int lat);
        @(negedge clk);
        chk("in_ready_before_send", 32'(bus.in_ready), 1);
        bus.bcd_in   = bcd;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.bcd_in   = 16'hFFFF;
        chk("in_ready_in_conv", 32'(bus.in_ready), 0);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1 && bus.out_valid) begin lat = 0; break; end
            if (c > 1 && bus.out_valid) begin lat = c - 1; break; end
        end
        if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    int lat;
    int exp_lat;
    logic [13:0] held_bin;
    logic        held_err;

    initial begin
        vecs[0] = '{16'h1234, 14'd1234,  1'b0, 4};
        vecs[1] = '{16'h9999, 14'd9999,  1'b0, 4};
        vecs[2] = '{16'h0000, 14'd0,     1'b0, 1};
        vecs[3] = '{16'h12A4, 14'd1304,  1'b1, 4};
        vecs[4] = '{16'h0001, 14'd1,     1'b0, 1};
        vecs[5] = '{16'h0007, 14'd7,     1'b0, 1};
        vecs[6] = '{16'h0120, 14'd120,   1'b0, 3};
        vecs[7] = '{16'h0A00, 14'd1000,  1'b1, 3};
        vecs[8] = '{16'hFFFF, 14'd281,   1'b1, 4};
        vecs[9] = '{16'h0905, 14'd905,   1'b0, 3};

        bus.in_valid  = 1'b0;
        bus.bcd_in    = 16'h0000;
        bus.out_ready = 1'b1;
        #12;
        chk("reset_in_ready",  32'(bus.in_ready), 1);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_bin_out",   32'(bus.bin_out), 0);
        chk("reset_err",       32'(bus.err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_no_capture", 32'(bus.in_ready), 1);

        foreach (vecs[i]) begin
`ifdef BCD2BIN_ZERO_SKIP_EN
            exp_lat = vecs[i].skip_lat;
`else
            exp_lat = 4;
`endif
            send(vecs[i].bcd, lat);
            chk($sformatf("latency_%h", vecs[i].bcd), 32'(lat), 32'(exp_lat));
            chk($sformatf("bin_%h", vecs[i].bcd), 32'(bus.bin_out), 32'(vecs[i].bin));
            chk($sformatf("err_%h", vecs[i].bcd), 32'(bus.err), 32'(vecs[i].err));
            chk("in_ready_in_done", 32'(bus.in_ready), 0);
            @(negedge clk);
            chk("out_valid_cleared", 32'(bus.out_valid), 0);
            chk("in_ready_after_done", 32'(bus.in_ready), 1);
        end

        // Backpressure: result held for 10 cycles while new input is offered and ignored
        bus.out_ready = 1'b0;
        send(16'h0315, lat);
        chk("bp_bin", 32'(bus.bin_out), 315);
        held_bin = bus.bin_out;
        held_err = bus.err;
        bus.bcd_in   = 16'h9999;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            chk("bp_bin_stable", 32'(bus.bin_out), 32'(held_bin));
            chk("bp_err_stable", 32'(bus.err), 32'(held_err));
            chk("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 32'(bus.out_valid), 0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        chk("bp_ignored_input", 32'(bus.in_ready), 1);

        // Reset asserted two cycles into a conversion aborts it immediately
        bus.bcd_in   = 16'h5678;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_bin_out", 32'(bus.bin_out), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        chk("abort_err", 32'(bus.err), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(bus.out_valid), 0);
        end
        send(16'h0042, lat);
        chk("after_abort_bin", 32'(bus.bin_out), 42);
        chk("after_abort_err", 32'(bus.err), 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
